// File: rtl/jtag_tap_target.sv
// jtag_tap_target
//   Target-side IEEE 1149.1 TAP responder. Runs the 16-state TAP FSM on the
//   rising edge of clk (TCK). It holds an instruction register and three data
//   registers: bypass, user-defined and boundary scan. tdo is driven from the
//   register contents.
//
// Ports
//   clk              in   TCK; all state changes on the rising edge
//   reset            in   asynchronous, active-high
//   tms, tdi         in   test mode select / test data in
//   bsr_capture_in   in   [BSR_WIDTH]   parallel pins loaded at Capture-DR (BSR)
//   tdo              out  serial data out (LSB of the active shift register)
//   tdo_en           out  high in Shift-IR / Shift-DR
//   tap_state        out  [4]          current TAP state
//   instruction      out  [INSTR_WIDTH] active instruction
//   user_reg         out  [USER_REG_WIDTH] user-defined register
//   bsr_update_out   out  [BSR_WIDTH]  boundary-scan update latch
//   update_dr_pulse  out  high while in Update-DR
module jtag_tap_target #(
  parameter int unsigned INSTR_WIDTH    = 5,
  parameter int unsigned USER_REG_WIDTH = 32,
  parameter int unsigned BSR_WIDTH      = 32,
  parameter logic [4:0]  OPC_BYPASS     = 5'b00000,
  parameter logic [4:0]  OPC_USER       = 5'b00001,
  parameter logic [4:0]  OPC_BSR        = 5'b00110
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      tms,
  input  logic                      tdi,
  input  logic [BSR_WIDTH-1:0]      bsr_capture_in,
  output logic                      tdo,
  output logic                      tdo_en,
  output logic [3:0]                tap_state,
  output logic [INSTR_WIDTH-1:0]    instruction,
  output logic [USER_REG_WIDTH-1:0] user_reg,
  output logic [BSR_WIDTH-1:0]      bsr_update_out,
  output logic                      update_dr_pulse
);

  typedef enum logic [3:0] {
    TAP_RESET      = 4'd0,
    TAP_IDLE       = 4'd1,
    TAP_DR_SCAN    = 4'd2,
    TAP_IR_SCAN    = 4'd3,
    TAP_CAPTURE_IR = 4'd4,
    TAP_SHIFT_IR   = 4'd5,
    TAP_EXIT1_IR   = 4'd6,
    TAP_PAUSE_IR   = 4'd7,
    TAP_EXIT2_IR   = 4'd8,
    TAP_UPDATE_IR  = 4'd9,
    TAP_CAPTURE_DR = 4'd10,
    TAP_SHIFT_DR   = 4'd11,
    TAP_EXIT1_DR   = 4'd12,
    TAP_PAUSE_DR   = 4'd13,
    TAP_EXIT2_DR   = 4'd14,
    TAP_UPDATE_DR  = 4'd15
  } tap_state_e;

  localparam logic [INSTR_WIDTH-1:0] OPC_BYPASS_L = OPC_BYPASS[INSTR_WIDTH-1:0];
  localparam logic [INSTR_WIDTH-1:0] OPC_USER_L   = OPC_USER[INSTR_WIDTH-1:0];
  localparam logic [INSTR_WIDTH-1:0] OPC_BSR_L    = OPC_BSR[INSTR_WIDTH-1:0];
  // 1149.1 mandates the two LSBs of the IR capture value be 2'b01.
  localparam logic [INSTR_WIDTH-1:0] IR_CAPTURE   = {{(INSTR_WIDTH-2){1'b0}}, 2'b01};

  tap_state_e                state_q;
  logic [INSTR_WIDTH-1:0]    instr_q;
  logic [INSTR_WIDTH-1:0]    ir_shift_q;
  logic                      bypass_q;
  logic [USER_REG_WIDTH-1:0] user_shift_q;
  logic [BSR_WIDTH-1:0]      bsr_shift_q;
  logic [USER_REG_WIDTH-1:0] user_reg_q;
  logic [BSR_WIDTH-1:0]      bsr_upd_q;

  // Any opcode other than USER or BSR (including undefined ones) selects bypass.
  logic sel_user;
  logic sel_bsr;
  assign sel_user = (instr_q == OPC_USER_L);
  assign sel_bsr  = (instr_q == OPC_BSR_L) && !sel_user;

  // Register actions belong to the state being left, so they are keyed on
  // state_q together with the transition out of it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= TAP_RESET;
      instr_q      <= OPC_BYPASS_L;
      ir_shift_q   <= '0;
      bypass_q     <= 1'b0;
      user_shift_q <= '0;
      bsr_shift_q  <= '0;
      user_reg_q   <= '0;
      bsr_upd_q    <= '0;
    end else begin
      case (state_q)
        TAP_RESET: begin
          instr_q <= OPC_BYPASS_L;
          state_q <= tms ? TAP_RESET : TAP_IDLE;
        end
        TAP_IDLE:    state_q <= tms ? TAP_DR_SCAN : TAP_IDLE;
        TAP_DR_SCAN: state_q <= tms ? TAP_IR_SCAN : TAP_CAPTURE_DR;
        TAP_IR_SCAN: begin
          if (tms) begin
            state_q <= TAP_RESET;
            instr_q <= OPC_BYPASS_L;
          end else begin
            state_q <= TAP_CAPTURE_IR;
          end
        end
        TAP_CAPTURE_IR: begin
          ir_shift_q <= IR_CAPTURE;
          state_q    <= tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
        end
        TAP_SHIFT_IR: begin
          ir_shift_q <= {tdi, ir_shift_q[INSTR_WIDTH-1:1]};
          state_q    <= tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
        end
        TAP_EXIT1_IR: state_q <= tms ? TAP_UPDATE_IR : TAP_PAUSE_IR;
        TAP_PAUSE_IR: state_q <= tms ? TAP_EXIT2_IR : TAP_PAUSE_IR;
        TAP_EXIT2_IR: state_q <= tms ? TAP_UPDATE_IR : TAP_SHIFT_IR;
        TAP_UPDATE_IR: begin
          instr_q <= ir_shift_q;
          state_q <= tms ? TAP_DR_SCAN : TAP_IDLE;
        end
        TAP_CAPTURE_DR: begin
          if (sel_user)     user_shift_q <= user_reg_q;
          else if (sel_bsr) bsr_shift_q  <= bsr_capture_in;
          else              bypass_q     <= 1'b0;
          state_q <= tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
        end
        TAP_SHIFT_DR: begin
          if (sel_user)     user_shift_q <= {tdi, user_shift_q[USER_REG_WIDTH-1:1]};
          else if (sel_bsr) bsr_shift_q  <= {tdi, bsr_shift_q[BSR_WIDTH-1:1]};
          else              bypass_q     <= tdi;
          state_q <= tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
        end
        TAP_EXIT1_DR: state_q <= tms ? TAP_UPDATE_DR : TAP_PAUSE_DR;
        TAP_PAUSE_DR: state_q <= tms ? TAP_EXIT2_DR : TAP_PAUSE_DR;
        TAP_EXIT2_DR: state_q <= tms ? TAP_UPDATE_DR : TAP_SHIFT_DR;
        TAP_UPDATE_DR: begin
          if (sel_user)     user_reg_q <= user_shift_q;
          else if (sel_bsr) bsr_upd_q  <= bsr_shift_q;
          state_q <= tms ? TAP_DR_SCAN : TAP_IDLE;
        end
        default: state_q <= TAP_RESET;
      endcase
    end
  end

  always_comb begin
    tdo = 1'b0;
    if (state_q == TAP_SHIFT_IR) begin
      tdo = ir_shift_q[0];
    end else if (state_q == TAP_SHIFT_DR) begin
      if (sel_user)     tdo = user_shift_q[0];
      else if (sel_bsr) tdo = bsr_shift_q[0];
      else              tdo = bypass_q;
    end
  end

  assign tdo_en          = (state_q == TAP_SHIFT_IR) || (state_q == TAP_SHIFT_DR);
  assign tap_state       = state_q;
  assign instruction     = instr_q;
  assign user_reg        = user_reg_q;
  assign bsr_update_out  = bsr_upd_q;
  assign update_dr_pulse = (state_q == TAP_UPDATE_DR);

endmodule

// File: tb/tb_jtag_tap_target.sv
// tb_jtag_tap_target
//   Self-checking bench for jtag_tap_target. Expected tdo bits for each scan
//   are pushed to a queue as the scan is driven and popped as tdo is sampled.
module tb_jtag_tap_target;

  localparam int unsigned IW = 5;

  logic        clk;
  logic        reset;
  logic        tms;
  logic        tdi;
  logic [31:0] bsr_capture_in;
  logic        tdo;
  logic        tdo_en;
  logic [3:0]  tap_state;
  logic [IW-1:0] instruction;
  logic [31:0] user_reg;
  logic [31:0] bsr_update_out;
  logic        update_dr_pulse;

  int n_cmp = 0;
  int n_err = 0;

  // Bench model of the architecturally visible state.
  logic [IW-1:0] m_instr;
  logic [31:0]   m_user;
  logic [31:0]   m_bsr_upd;
  logic          exp_q[$];

  jtag_tap_target #(
    .INSTR_WIDTH(5),
    .USER_REG_WIDTH(32),
    .BSR_WIDTH(32),
    .OPC_BYPASS(5'b00000),
    .OPC_USER(5'b00001),
    .OPC_BSR(5'b00110)
  ) dut (
    .clk(clk),
    .reset(reset),
    .tms(tms),
    .tdi(tdi),
    .bsr_capture_in(bsr_capture_in),
    .tdo(tdo),
    .tdo_en(tdo_en),
    .tap_state(tap_state),
    .instruction(instruction),
    .user_reg(user_reg),
    .bsr_update_out(bsr_update_out),
    .update_dr_pulse(update_dr_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one TCK cycle; returns 1 time unit after the rising edge.
  task automatic tick(input logic t_ms, input logic t_di);
    tms = t_ms;
    tdi = t_di;
    @(posedge clk);
    #1;
  endtask

  task automatic pop_chk(input string tag);
    logic e;
    if (exp_q.size() == 0) begin
      chk({tag, "_underflow"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      chk(tag, tdo, e);
    end
  endtask

  // Idle -> IR scan of val -> Idle.
  task automatic scan_ir(input logic [IW-1:0] val);
    tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    chk("ir_shift_state", tap_state, 4'd5);
    chk("ir_tdo_en", tdo_en, 1'b1);
    // Capture value 01 comes out LSB first, then zeros.
    for (int unsigned i = 0; i < IW; i++) exp_q.push_back(i == 0);
    for (int unsigned i = 0; i < IW; i++) begin
      pop_chk("ir_tdo");
      tick(i == IW - 1, val[i]);
    end
    chk("ir_exit1_state", tap_state, 4'd6);
    tick(1, 0);
    chk("ir_update_state", tap_state, 4'd9);
    tick(0, 0);
    m_instr = val;
    chk("ir_instruction", instruction, m_instr);
    chk("ir_idle_state", tap_state, 4'd1);
    chk("ir_queue_empty", exp_q.size(), 0);
  endtask

  // Idle -> DR scan of n bits -> Idle. pause_at>0 leaves Shift-DR after that
  // many bits, pauses three cycles, and resumes through Exit2-DR.
  task automatic scan_dr(input int unsigned n, input logic [31:0] din, input int unsigned pause_at);
    logic is_user;
    logic is_bsr;
    is_user = (m_instr == 5'b00001);
    is_bsr  = (m_instr == 5'b00110);
    for (int unsigned i = 0; i < n; i++) begin
      if (is_user)     exp_q.push_back(m_user[i]);
      else if (is_bsr) exp_q.push_back(bsr_capture_in[i]);
      else             exp_q.push_back(i == 0 ? 1'b0 : din[i-1]);
    end
    tick(1, 0); tick(0, 0); tick(0, 0);
    chk("dr_shift_state", tap_state, 4'd11);
    chk("dr_tdo_en", tdo_en, 1'b1);
    for (int unsigned i = 0; i < n; i++) begin
      pop_chk("dr_tdo");
      tick((i == n - 1) || (i + 1 == pause_at), din[i]);
      if ((i + 1 == pause_at) && (i != n - 1)) begin
        chk("pause_exit1", tap_state, 4'd12);
        tick(0, 0);
        chk("pause_state", tap_state, 4'd13);
        tick(0, 1); tick(0, 1);
        chk("pause_hold", tap_state, 4'd13);
        chk("pause_tdo_en", tdo_en, 1'b0);
        chk("pause_tdo", tdo, 1'b0);
        tick(1, 0);
        chk("pause_exit2", tap_state, 4'd14);
        tick(0, 0);
        chk("pause_resume", tap_state, 4'd11);
      end
    end
    chk("dr_exit1_state", tap_state, 4'd12);
    chk("dr_pulse_pre", update_dr_pulse, 1'b0);
    tick(1, 0);
    chk("dr_update_state", tap_state, 4'd15);
    chk("dr_pulse", update_dr_pulse, 1'b1);
    tick(0, 0);
    chk("dr_pulse_post", update_dr_pulse, 1'b0);
    chk("dr_idle_state", tap_state, 4'd1);
    if (is_user)     m_user    = din;
    else if (is_bsr) m_bsr_upd = din;
    chk("dr_user_reg", user_reg, m_user);
    chk("dr_bsr_update", bsr_update_out, m_bsr_upd);
    chk("dr_queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    reset = 1'b1;
    tms = 1'b1;
    tdi = 1'b0;
    bsr_capture_in = 32'h0;
    m_instr = '0;
    m_user = '0;
    m_bsr_upd = '0;
    #12;
    chk("rst_state", tap_state, 4'd0);
    chk("rst_instr", instruction, 5'b00000);
    chk("rst_user", user_reg, 32'h0);
    chk("rst_bsr", bsr_update_out, 32'h0);
    chk("rst_tdo", tdo, 1'b0);
    chk("rst_tdo_en", tdo_en, 1'b0);
    chk("rst_pulse", update_dr_pulse, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) tick(1, 0);
    chk("tlr_state", tap_state, 4'd0);
    chk("tlr_instr", instruction, 5'b00000);
    chk("tlr_tdo_en", tdo_en, 1'b0);
    tick(0, 0);
    chk("idle_state", tap_state, 4'd1);

    // User register write, then read back by shifting zeros.
    scan_ir(5'b00001);
    scan_dr(32, 32'hA5A5_1234, 0);
    scan_dr(32, 32'h0000_0000, 0);
    // Pause after 8 bits, resume for the remaining 24.
    scan_dr(32, 32'h1357_9BDF, 8);

    // Boundary scan capture / update.
    bsr_capture_in = 32'hDEAD_BEEF;
    scan_ir(5'b00110);
    scan_dr(32, 32'h0F0F_0F0F, 0);

    // Five tms=1 from Idle: instruction reloads bypass, data registers held.
    for (int i = 0; i < 5; i++) tick(1, 0);
    m_instr = 5'b00000;
    chk("tlr2_state", tap_state, 4'd0);
    chk("tlr2_instr", instruction, m_instr);
    chk("tlr2_user_held", user_reg, m_user);
    chk("tlr2_bsr_held", bsr_update_out, m_bsr_upd);
    tick(0, 0);

    // Undefined opcode behaves as bypass: tdi pattern 1,0,1,1.
    scan_ir(5'b10101);
    scan_dr(4, 32'h0000_000D, 0);

    // Asynchronous reset in the middle of a user DR shift.
    scan_ir(5'b00001);
    tick(1, 0); tick(0, 0); tick(0, 0);
    for (int i = 0; i < 10; i++) tick(0, 1);
    chk("abort_pre_state", tap_state, 4'd11);
    #2;
    reset = 1'b1;
    #1;
    m_instr = '0; m_user = '0; m_bsr_upd = '0;
    chk("abort_state", tap_state, 4'd0);
    chk("abort_instr", instruction, m_instr);
    chk("abort_user", user_reg, m_user);
    chk("abort_bsr", bsr_update_out, m_bsr_upd);
    chk("abort_tdo", tdo, 1'b0);
    chk("abort_tdo_en", tdo_en, 1'b0);
    chk("abort_pulse", update_dr_pulse, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    tick(0, 0);
    chk("abort_idle", tap_state, 4'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
